// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path.
//   DEF_DATA_W    : default sample width per channel
//   DEF_SLOT_W    : default BCLK periods per channel slot
//   DEF_BCLK_HALF : default system clocks per BCLK half-period
//   stereo_sample_t : one left/right sample pair at the default width
package i2s_pkg;

  localparam int DEF_DATA_W    = 24;
  localparam int DEF_SLOT_W    = 32;
  localparam int DEF_BCLK_HALF = 4;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] left;
    logic [DEF_DATA_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator for the I2S transmitter.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   en        : run enable; low parks the divider and holds bclk at 0
//   bclk      : registered bit clock, half-period of BCLK_HALF clks
//   rise_tick : high in the clk whose edge takes bclk 0->1
//   fall_tick : high in the clk whose edge takes bclk 1->0
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // The strobes announce the toggle that the next edge performs, so the
  // sequencer can update lrclk/sdata on the very same edge as bclk.
  assign wrap      = en && (div_cnt == DIV_LAST);
  assign rise_tick = wrap && !bclk;
  assign fall_tick = wrap && bclk;

  // Divider: parking bclk low while disabled guarantees that the first
  // toggle after enable is a rising one.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= !bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S serializer towards the codec DAC.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   en                 : run enable; low drives bclk/lrclk/sdata to 0
//   in_valid/in_ready  : sample-pair handshake into a one-deep holding register
//   in_left, in_right  : two's complement samples, DATA_W bits each
//   bclk, lrclk, sdata : registered I2S bus, MSB first, one-BCLK data delay
//   frame_start        : one-clk pulse when a frame is loaded
//   underflow          : one-clk pulse when a frame is loaded with nothing held
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SLOT_W    = DEF_SLOT_W,
  parameter int BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underflow
);

  localparam int K_W = $clog2(2 * SLOT_W);
  localparam logic [K_W-1:0] K_LAST  = K_W'(2 * SLOT_W - 1);
  localparam logic [K_W-1:0] K_SLOT  = K_W'(SLOT_W);
  localparam logic [K_W-1:0] K_L_END = K_W'(DATA_W);
  localparam logic [K_W-1:0] K_R_BEG = K_W'(SLOT_W + 1);
  localparam logic [K_W-1:0] K_R_END = K_W'(SLOT_W + DATA_W);

  logic              rise_tick;
  logic              fall_tick;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] hold_left;
  logic [DATA_W-1:0] hold_right;
  logic              hold_full;
  logic [DATA_W-1:0] left_sr;
  logic [DATA_W-1:0] right_sr;
  logic              next_bit;
  logic              accept;
  logic              load;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bclk      (bclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign accept = in_valid && in_ready;
  assign load   = fall_tick && (k == '0);

  // Holding register. in_ready mirrors !hold_full as a register, and an
  // accept can only meet a load that finds the register empty (an
  // underflow load), so the two never fight over hold_full.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_left  <= '0;
      hold_right <= '0;
      hold_full  <= 1'b0;
      in_ready   <= 1'b1;
    end else if (accept) begin
      hold_left  <= in_left;
      hold_right <= in_right;
      hold_full  <= 1'b1;
      in_ready   <= 1'b0;
    end else if (load) begin
      hold_full  <= 1'b0;
      in_ready   <= 1'b1;
    end
  end

  // Frame sequencer. k is the index of the upcoming fall tick. The data bit
  // for that fall is pulled out of the shift registers on the preceding rise
  // tick, so the fall tick itself is a plain register transfer. The rise
  // before k=1 always follows the k=0 load, so it sees the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= '0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      next_bit    <= 1'b0;
      left_sr     <= '0;
      right_sr    <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= load;
      underflow   <= load && !hold_full;
      if (!en) begin
        k        <= '0;
        lrclk    <= 1'b0;
        sdata    <= 1'b0;
        next_bit <= 1'b0;
      end else begin
        if (rise_tick) begin
          if ((k != '0) && (k <= K_L_END)) begin
            next_bit <= left_sr[DATA_W-1];
            left_sr  <= left_sr << 1;
          end else if ((k >= K_R_BEG) && (k <= K_R_END)) begin
            next_bit <= right_sr[DATA_W-1];
            right_sr <= right_sr << 1;
          end else begin
            next_bit <= 1'b0;
          end
        end
        if (fall_tick) begin
          lrclk <= (k >= K_SLOT);
          sdata <= next_bit;
          k     <= (k == K_LAST) ? '0 : k + 1'b1;
          if (k == '0) begin
            if (hold_full) begin
              left_sr  <= hold_left;
              right_sr <= hold_right;
            end else begin
              left_sr  <= '0;
              right_sr <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx (DATA_W=24, SLOT_W=32, BCLK_HALF=2).
// A time-based model predicts every output each clk, an I2S receiver decodes
// the serial bus and checks the words against the frames the model loaded,
// and directed phases pin the model with hand-computed literals.
`timescale 1ns/1ps
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int D = 24;
  localparam int S = 32;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         in_valid;
  logic [D-1:0] in_left;
  logic [D-1:0] in_right;
  logic         in_ready;
  logic         bclk;
  logic         lrclk;
  logic         sdata;
  logic         frame_start;
  logic         underflow;

  i2s_tx #(
    .DATA_W    (D),
    .SLOT_W    (S),
    .BCLK_HALF (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .in_valid    (in_valid),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_ready    (in_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts enabled clk edges since enable/reset. bclk
  // toggles every H edges starting high, fall ticks land on multiples of
  // 2H, and fall tick m carries bit index (m-1) mod 2S of the current frame.
  int             t;
  int             mk;
  bit             m_live = 1'b0;
  bit             m_hold_full;
  bit             m_accept = 1'b0;
  bit             rx_flush = 1'b0;
  stereo_sample_t m_hold;
  stereo_sample_t m_frame;
  stereo_sample_t sent_q[$];
  logic e_bclk, e_lrclk, e_sdata, e_fs, e_uf, e_ready;

  function automatic logic slot_bit(input stereo_sample_t f, input int kk);
    if (kk >= 1 && kk <= D) return f.left[D-kk];
    if (kk >= S + 1 && kk <= S + D) return f.right[D-(kk-S)];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    m_accept = 1'b0;
    if (rst === 1'b1) begin
      m_live = 1'b1;
      t = 0;
      m_hold_full = 1'b0;
      m_hold = '0;
      m_frame = '0;
      e_bclk = 0; e_lrclk = 0; e_sdata = 0; e_fs = 0; e_uf = 0; e_ready = 1;
      sent_q.delete();
      rx_flush = 1'b1;
    end else if (m_live) begin
      m_accept = (in_valid === 1'b1) && e_ready;
      e_fs = 0;
      e_uf = 0;
      if (en === 1'b1) begin
        t++;
        e_bclk = ((t / H) % 2) == 1;
        if (t % (2 * H) == 0) begin
          mk = ((t / (2 * H)) - 1) % (2 * S);
          if (mk == 0) begin
            e_fs = 1;
            if (m_hold_full) begin
              m_frame = m_hold;
              m_hold_full = 1'b0;
            end else begin
              m_frame = '0;
              e_uf = 1;
            end
            sent_q.push_back(m_frame);
          end
          e_lrclk = (mk >= S);
          e_sdata = slot_bit(m_frame, mk);
        end
      end else begin
        t = 0;
        e_bclk = 0; e_lrclk = 0; e_sdata = 0;
        sent_q.delete();
        rx_flush = 1'b1;
      end
      if (m_accept) begin
        m_hold.left  = in_left;
        m_hold.right = in_right;
        m_hold_full  = 1'b1;
      end
      e_ready = !m_hold_full;
    end
  end

  // Per-clk comparison plus an I2S receiver sampling sdata on bclk rising.
  logic         rx_prev_bclk = 1'b0;
  logic         rx_prev_lr = 1'b1;
  bit           rx_armed = 1'b0;
  int           rx_pos = 0;
  logic [D-1:0] rx_word = '0;
  logic [31:0]  rx_log[$];

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("bclk",        32'(bclk),        32'(e_bclk));
      checkOutput("lrclk",       32'(lrclk),       32'(e_lrclk));
      checkOutput("sdata",       32'(sdata),       32'(e_sdata));
      checkOutput("frame_start", 32'(frame_start), 32'(e_fs));
      checkOutput("underflow",   32'(underflow),   32'(e_uf));
      checkOutput("in_ready",    32'(in_ready),    32'(e_ready));
      if (rx_flush) begin
        rx_flush   = 1'b0;
        rx_armed   = 1'b0;
        rx_prev_lr = 1'b1;
        rx_pos     = 0;
      end
      if (bclk === 1'b1 && rx_prev_bclk === 1'b0) begin
        if (!rx_armed && sent_q.size() > 0) rx_armed = 1'b1;
        if (rx_armed) begin
          if (lrclk !== rx_prev_lr) begin
            rx_pos = 0;
            rx_prev_lr = lrclk;
          end else begin
            rx_pos++;
            if (rx_pos <= D) rx_word = {rx_word[D-2:0], sdata};
            if (rx_pos == D) begin
              rx_log.push_back(32'(rx_word));
              checkOutput("rx_frame_pending", 32'(sent_q.size() > 0), 32'd1);
              if (sent_q.size() > 0) begin
                if (lrclk === 1'b0) begin
                  checkOutput("rx_left", 32'(rx_word), 32'(sent_q[0].left));
                end else begin
                  checkOutput("rx_right", 32'(rx_word), 32'(sent_q[0].right));
                  void'(sent_q.pop_front());
                end
              end
            end
          end
        end
      end
      rx_prev_bclk = bclk;
    end
  end

  // Sample source: offers src_count pairs, keeping each stable until taken.
  int           src_count = 0;
  bit           src_gaps = 1'b0;
  bit           offering = 1'b0;
  bit           use_fix = 1'b0;
  logic [D-1:0] fix_l, fix_r, cur_l, cur_r;

  initial begin
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    cur_l    = '0;
    cur_r    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_accept) begin
        offering = 1'b0;
        if (src_count > 0) src_count--;
      end
      if (src_count == 0) offering = 1'b0;
      if (!offering && src_count > 0) begin
        if (use_fix) begin
          cur_l = fix_l;
          cur_r = fix_r;
          use_fix = 1'b0;
        end else begin
          cur_l = D'($urandom);
          cur_r = D'($urandom);
        end
        offering = 1'b1;
      end
      in_valid = offering && (!src_gaps || $urandom_range(0, 3) != 0);
      in_left  = cur_l;
      in_right = cur_r;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int cycles);
    rst = r;
    en  = e;
    tick(cycles);
  endtask

  // Counts clk edges until frame_start is seen, giving up after 64.
  task automatic clocksToFrameStart(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (frame_start !== 1'b1 && n < 64);
  endtask

  task automatic runCount(input int n, inout int fs, inout int uf);
    repeat (n) begin
      tick(1);
      if (frame_start === 1'b1) fs++;
      if (underflow === 1'b1) uf++;
    end
  endtask

  int   n, fs_n, uf_n, lr_hi, sd_hi, rises, r;
  logic prevb;

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("rst_bclk",     32'(bclk),        32'd0);
    checkOutput("rst_lrclk",    32'(lrclk),       32'd0);
    checkOutput("rst_sdata",    32'(sdata),       32'd0);
    checkOutput("rst_fs",       32'(frame_start), 32'd0);
    checkOutput("rst_uf",       32'(underflow),   32'd0);
    checkOutput("rst_in_ready", 32'(in_ready),    32'd1);

    // Idle run: silent frames with underflow, bus timing
    applyStimulus(1'b0, 1'b1, 0);
    clocksToFrameStart(n);
    checkOutput("idle_first_fs_clks", 32'(n), 32'd4);
    checkOutput("idle_first_uf", 32'(underflow), 32'd1);
    fs_n = 0; uf_n = 0; lr_hi = 0; sd_hi = 0; rises = 0;
    prevb = bclk;
    repeat (256) begin
      tick(1);
      if (lrclk === 1'b1) lr_hi++;
      if (sdata === 1'b1) sd_hi++;
      if (frame_start === 1'b1) fs_n++;
      if (underflow === 1'b1) uf_n++;
      if (bclk === 1'b1 && prevb === 1'b0) rises++;
      prevb = bclk;
    end
    checkOutput("idle_lrclk_high_clks", 32'(lr_hi), 32'd128);
    checkOutput("idle_sdata_ones", 32'(sd_hi), 32'd0);
    checkOutput("idle_fs_per_frame", 32'(fs_n), 32'd1);
    checkOutput("idle_uf_per_frame", 32'(uf_n), 32'd1);
    checkOutput("idle_bclk_rises", 32'(rises), 32'd64);

    // Known pair loaded before enable
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b0;
    fix_l = 24'hA5F00F;
    fix_r = 24'h800001;
    use_fix = 1'b1;
    src_count = 1;
    tick(3);
    rx_log.delete();
    en = 1'b1;
    clocksToFrameStart(n);
    checkOutput("known_first_fs_clks", 32'(n), 32'd4);
    checkOutput("known_uf", 32'(underflow), 32'd0);
    tick(300);
    checkOutput("known_rx_words", 32'(rx_log.size() >= 2), 32'd1);
    if (rx_log.size() >= 2) begin
      checkOutput("known_left_word", rx_log[0], 32'h00A5F00F);
      checkOutput("known_right_word", rx_log[1], 32'h00800001);
    end

    // Back-to-back stream of four pairs
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b0;
    src_count = 4;
    tick(2);
    en = 1'b1;
    fs_n = 0; uf_n = 0;
    runCount(1020, fs_n, uf_n);
    checkOutput("stream_fs", 32'(fs_n), 32'd4);
    checkOutput("stream_uf", 32'(uf_n), 32'd0);

    // Starved source, refilled during the silent frame
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b0;
    src_count = 2;
    tick(2);
    en = 1'b1;
    fs_n = 0; uf_n = 0;
    runCount(600, fs_n, uf_n);
    src_count = 1;
    runCount(420, fs_n, uf_n);
    checkOutput("starve_fs", 32'(fs_n), 32'd4);
    checkOutput("starve_uf", 32'(uf_n), 32'd1);

    // Reset inside the right slot
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b0;
    src_count = 3;
    tick(2);
    en = 1'b1;
    tick(165);
    checkOutput("midrst_lrclk_before", 32'(lrclk), 32'd1);
    rst = 1'b1;
    tick(1);
    checkOutput("midrst_bclk", 32'(bclk), 32'd0);
    checkOutput("midrst_lrclk", 32'(lrclk), 32'd0);
    checkOutput("midrst_sdata", 32'(sdata), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    clocksToFrameStart(n);
    checkOutput("midrst_restart_clks", 32'(n), 32'd4);
    tick(400);

    // Enable dropped for 100 clks with a pair held
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b0;
    src_count = 2;
    tick(2);
    en = 1'b1;
    tick(200);
    checkOutput("pause_lrclk_before", 32'(lrclk), 32'd1);
    checkOutput("pause_ready_before", 32'(in_ready), 32'd0);
    en = 1'b0;
    tick(2);
    checkOutput("pause_bclk", 32'(bclk), 32'd0);
    checkOutput("pause_lrclk", 32'(lrclk), 32'd0);
    checkOutput("pause_sdata", 32'(sdata), 32'd0);
    checkOutput("pause_in_ready", 32'(in_ready), 32'd0);
    tick(98);
    en = 1'b1;
    clocksToFrameStart(n);
    checkOutput("pause_restart_clks", 32'(n), 32'd4);
    checkOutput("pause_restart_uf", 32'(underflow), 32'd0);
    tick(300);

    // Randomized traffic with occasional resets and enable drops
    src_gaps = 1'b1;
    for (int it = 0; it < 12; it++) begin
      src_count = src_count + $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        applyStimulus(1'b1, 1'b1, $urandom_range(1, 3));
        rst = 1'b0;
      end else if (r < 3) begin
        applyStimulus(1'b0, 1'b0, $urandom_range(1, 60));
        en = 1'b1;
      end
      tick($urandom_range(50, 700));
    end
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
